// File: rtl/prog_host_ctrl.sv
// Host-side initiator for the 9-bit core: preload data memory, reset and run the core, drain results.
// Optional running checksum of drained bytes is compiled in with `define HOST_CHECKSUM_EN.
module prog_host_ctrl #(
  parameter int unsigned AW        = 8,
  parameter int unsigned LOAD_BASE = 0,
  parameter int unsigned LOAD_LEN  = 64,
  parameter int unsigned RES_BASE  = 64,
  parameter int unsigned RES_LEN   = 32,
  parameter int unsigned RST_CYC   = 4,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          core_rst,
  output logic          core_req,
  input  logic          core_done,
  output logic          host_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wr_dat,
  input  logic [7:0]    mem_rd_dat,
  output logic          busy,
  output logic          job_done,
  output logic          timeout_err,
  output logic [15:0]   run_cycles,
  output logic [7:0]    checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CRST,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [15:0]   run_cycles_q, run_cycles_d;
  logic          timeout_err_q, timeout_err_d;
  logic          job_done_q, job_done_d;
  logic [15:0]   run_inc;
  logic          in_xfer;
  logic          out_xfer;
`ifdef HOST_CHECKSUM_EN
  logic [7:0]    checksum_q, checksum_d;
`endif

  // Saturating RUN counter; the timeout compares the post-increment value so
  // a TIMEOUT of N allows exactly N RUN cycles.
  assign run_inc  = (run_cycles_q == 16'hFFFF) ? run_cycles_q : run_cycles_q + 16'd1;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    run_cycles_d  = run_cycles_q;
    timeout_err_d = timeout_err_q;
    job_done_d    = 1'b0;
`ifdef HOST_CHECKSUM_EN
    checksum_d    = checksum_q;
`endif
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    core_rst      = 1'b1;
    core_req      = 1'b0;
    host_sel      = 1'b1;
    mem_wr_en     = 1'b0;
    mem_addr      = ptr_q;
    mem_wr_dat    = in_data;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          timeout_err_d = 1'b0;
          run_cycles_d  = 16'd0;
`ifdef HOST_CHECKSUM_EN
          checksum_d    = 8'd0;
`endif
          ptr_d         = AW'(LOAD_BASE);
          cnt_d         = 32'd0;
          state_d       = (LOAD_LEN == 0) ? S_CRST : S_LOAD;
        end
      end

      S_LOAD: begin
        in_ready  = 1'b1;
        mem_wr_en = in_xfer;
        if (in_xfer) begin
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == LOAD_LEN - 1) begin
            cnt_d   = 32'd0;
            state_d = S_CRST;
          end
        end
      end

      S_CRST: begin
        // A zero RST_CYC still spends one cycle here.
        if (cnt_q + 32'd1 >= RST_CYC) begin
          cnt_d   = 32'd0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_RUN: begin
        core_rst     = 1'b0;
        host_sel     = 1'b0;
        core_req     = 1'b1;
        run_cycles_d = run_inc;
        if (core_done) begin
          ptr_d   = AW'(RES_BASE);
          cnt_d   = 32'd0;
          state_d = S_DRAIN;
        end else if (32'(run_inc) >= TIMEOUT) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end

      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_xfer) begin
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_q + 32'd1;
`ifdef HOST_CHECKSUM_EN
          checksum_d = checksum_q + mem_rd_dat;
`endif
          if (cnt_q == RES_LEN - 1) begin
            job_done_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= 32'd0;
      run_cycles_q  <= 16'd0;
      timeout_err_q <= 1'b0;
      job_done_q    <= 1'b0;
`ifdef HOST_CHECKSUM_EN
      checksum_q    <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      run_cycles_q  <= run_cycles_d;
      timeout_err_q <= timeout_err_d;
      job_done_q    <= job_done_d;
`ifdef HOST_CHECKSUM_EN
      checksum_q    <= checksum_d;
`endif
    end
  end

  assign out_data    = mem_rd_dat;
  assign busy        = (state_q != S_IDLE);
  assign job_done    = job_done_q;
  assign timeout_err = timeout_err_q;
  assign run_cycles  = run_cycles_q;
`ifdef HOST_CHECKSUM_EN
  assign checksum    = checksum_q;
`else
  assign checksum    = 8'h00;
`endif

endmodule
